// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates between two requesters (CPU and IO) for one data memory with a
// pulsed write strobe. Each access passes through IDLE -> SETUP -> PULSE ->
// DONE. When both request together, a round-robin pointer decides who wins.
// Writes are legal only to the lower quarter of the address space
// (addr[ADDR_W-1:ADDR_W-2] == 2'b00). Other writes never reach the memory and
// complete with an error flag.
//
// Every output is registered, so each output phase appears one clock after
// the state that computes it:
//   edge N   : IDLE samples the requests and latches the winner's access
//   edge N+1 : SETUP drives mem_addr / mem_din / mem_we
//   edge N+2 : PULSE raises mem_tp for one cycle (legal writes only)
//   edge N+3 : DONE captures rdata and raises the winner's ack / err
//   edge N+4 : IDLE clears ack and mem_we and may accept the next request
//
// Ports
//   clk                   sole clock, rising edge
//   reset_n               asynchronous active-low reset
//   cpu_req / io_req      access requests
//   cpu_we / io_we        1 = write, 0 = read
//   cpu_addr / io_addr    word address (ADDR_W bits)
//   cpu_wdata / io_wdata  write data (DATA_W bits)
//   cpu_ack / io_ack      one-cycle completion pulse
//   cpu_err / io_err      valid with ack; 1 = write to fixed memory rejected
//   rdata                 read data, valid while ack is high, held otherwise
//   mem_addr / mem_din    address and write data to the data memory
//   mem_we                memory write enable (legal writes only)
//   mem_tp                memory timing pulse; memory writes on its rising edge
//   mem_dout              combinational read data from the data memory
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 15
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cpu_req,
   input  logic              io_req,
   input  logic              cpu_we,
   input  logic              io_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [ADDR_W-1:0] io_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic [DATA_W-1:0] io_wdata,
   output logic              cpu_ack,
   output logic              io_ack,
   output logic              cpu_err,
   output logic              io_err,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   output logic              mem_we,
   output logic              mem_tp,
   input  logic [DATA_W-1:0] mem_dout
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      PULSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t              state_q;
   logic                winner_io_q;   // 1 = IO owns the access in flight
   logic                last_io_q;     // 1 = IO was granted last; CPU preferred next
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;

   logic [ADDR_W-1:0]   mem_addr_q;
   logic [DATA_W-1:0]   mem_din_q;
   logic                mem_we_q;
   logic                mem_tp_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                cpu_ack_q;
   logic                io_ack_q;
   logic                cpu_err_q;
   logic                io_err_q;

   logic                grant_io_d;
   logic                legal_wr_d;
   logic                illegal_wr_d;

   always_comb begin
      // IO wins when it requests alone, or when both request and CPU was
      // served last.
      grant_io_d   = io_req && (!cpu_req || !last_io_q);
      legal_wr_d   = we_q && (addr_q[ADDR_W-1 -: 2] == 2'b00);
      illegal_wr_d = we_q && (addr_q[ADDR_W-1 -: 2] != 2'b00);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         winner_io_q <= 1'b0;
         last_io_q   <= 1'b1;        // makes CPU the preferred requester
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         mem_addr_q  <= '0;
         mem_din_q   <= '0;
         mem_we_q    <= 1'b0;
         mem_tp_q    <= 1'b0;
         rdata_q     <= '0;
         cpu_ack_q   <= 1'b0;
         io_ack_q    <= 1'b0;
         cpu_err_q   <= 1'b0;
         io_err_q    <= 1'b0;
      end else begin
         // Pulsed outputs default low; only the states below raise them.
         mem_tp_q  <= 1'b0;
         cpu_ack_q <= 1'b0;
         io_ack_q  <= 1'b0;
         cpu_err_q <= 1'b0;
         io_err_q  <= 1'b0;

         case (state_q)
            IDLE: begin
               // mem_we was held through the ack cycle; drop it here.
               mem_we_q <= 1'b0;
               if (cpu_req || io_req) begin
                  winner_io_q <= grant_io_d;
                  last_io_q   <= grant_io_d;
                  we_q        <= grant_io_d ? io_we    : cpu_we;
                  addr_q      <= grant_io_d ? io_addr  : cpu_addr;
                  wdata_q     <= grant_io_d ? io_wdata : cpu_wdata;
                  state_q     <= SETUP;
               end
            end
            SETUP: begin
               mem_addr_q <= addr_q;
               mem_din_q  <= wdata_q;
               mem_we_q   <= legal_wr_d;
               state_q    <= PULSE;
            end
            PULSE: begin
               mem_tp_q <= legal_wr_d;
               state_q  <= DONE;
            end
            DONE: begin
               // mem_dout here reflects the address held since SETUP and,
               // for a write, the word just stored by the tp pulse.
               rdata_q   <= mem_dout;
               cpu_ack_q <= !winner_io_q;
               io_ack_q  <= winner_io_q;
               cpu_err_q <= !winner_io_q && illegal_wr_d;
               io_err_q  <= winner_io_q && illegal_wr_d;
               state_q   <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign cpu_ack  = cpu_ack_q;
   assign io_ack   = io_ack_q;
   assign cpu_err  = cpu_err_q;
   assign io_err   = io_err_q;
   assign rdata    = rdata_q;
   assign mem_addr = mem_addr_q;
   assign mem_din  = mem_din_q;
   assign mem_we   = mem_we_q;
   assign mem_tp   = mem_tp_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter. A behavioural memory (4096 x 15) writes on
// the rising edge of mem_tp when mem_we is high and drives mem_dout
// combinationally. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 15;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              cpu_req, io_req, cpu_we, io_we;
   logic [ADDR_W-1:0] cpu_addr, io_addr;
   logic [DATA_W-1:0] cpu_wdata, io_wdata;
   logic              cpu_ack, io_ack, cpu_err, io_err;
   logic [DATA_W-1:0] rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_din;
   logic              mem_we, mem_tp;
   logic [DATA_W-1:0] mem_dout;

   logic [DATA_W-1:0] mem [0:4095];

   int n_checks = 0;
   int n_fail   = 0;
   int tp_cnt   = 0;
   int we_cnt   = 0;
   int ack_cnt  = 0;
   logic tp_prev = 1'b0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .cpu_req   (cpu_req),
      .io_req    (io_req),
      .cpu_we    (cpu_we),
      .io_we     (io_we),
      .cpu_addr  (cpu_addr),
      .io_addr   (io_addr),
      .cpu_wdata (cpu_wdata),
      .io_wdata  (io_wdata),
      .cpu_ack   (cpu_ack),
      .io_ack    (io_ack),
      .cpu_err   (cpu_err),
      .io_err    (io_err),
      .rdata     (rdata),
      .mem_addr  (mem_addr),
      .mem_din   (mem_din),
      .mem_we    (mem_we),
      .mem_tp    (mem_tp),
      .mem_dout  (mem_dout)
   );

   // Memory model: preload, then write on each rising edge of mem_tp.
   assign mem_dout = mem[mem_addr];
   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = '0;
      mem[12'h020] = 15'h0ABC;
      mem[12'h3FF] = 15'h2A5C;
      mem[12'h800] = 15'h0111;
      forever begin
         @(posedge mem_tp);
         if (mem_we) mem[mem_addr] = mem_din;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Bus monitor sampled on the falling edge.
   always @(negedge clk) begin
      chk("ack_overlap", 32'(cpu_ack & io_ack), 32'd0);
      if (mem_tp) begin
         tp_cnt++;
         chk("tp_with_we", 32'(mem_we), 32'd1);
         chk("tp_single_cycle", 32'(tp_prev), 32'd0);
      end
      tp_prev = mem_tp;
      if (mem_we) we_cnt++;
      if (cpu_ack || io_ack) ack_cnt++;
   end

   // One complete access from one requester. lat = rising edges from the
   // accepting edge to the edge after which ack is seen (-1 if none).
   task automatic access(input bit io, input bit we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input bit drop_early,
                         output int lat, output logic [DATA_W-1:0] rd,
                         output logic er, output logic other);
      @(negedge clk);
      if (io) begin
         io_req = 1'b1; io_we = we; io_addr = a; io_wdata = d;
      end else begin
         cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
      end
      @(posedge clk); #1;
      if (drop_early) begin
         cpu_req = 1'b0; io_req = 1'b0;
      end
      lat = -1; rd = 'x; er = 1'bx; other = 1'bx;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         if (io ? io_ack : cpu_ack) begin
            lat   = k;
            rd    = rdata;
            er    = io ? io_err : cpu_err;
            other = io ? cpu_ack : io_ack;
            break;
         end
      end
      cpu_req = 1'b0; io_req = 1'b0; cpu_we = 1'b0; io_we = 1'b0;
      $display("access io=%0d we=%0d addr=0x%0h wdata=0x%0h lat=%0d rdata=0x%0h err=%0b",
               io, we, a, d, lat, rd, er);
   endtask

   // Both requesters hold requests until n acks are seen. who[i] = 1 when
   // the i-th ack was IO's; gap = cycles between the first two acks.
   task automatic both_run(input int n, output int got, output logic [3:0] who, output int gap);
      int t_first;
      @(negedge clk);
      cpu_req = 1'b1; io_req = 1'b1; cpu_we = 1'b0; io_we = 1'b0;
      cpu_addr = 12'h010; io_addr = 12'h3FF;
      got = 0; who = 4'b0000; gap = -1; t_first = 0;
      for (int cyc = 0; cyc < 60 && got < n; cyc++) begin
         @(negedge clk);
         if (cpu_ack || io_ack) begin
            who[got[1:0]] = io_ack;
            if (got == 0) t_first = cyc;
            else if (got == 1) gap = cyc - t_first;
            got++;
            $display("both-request ack #%0d to %s", got, io_ack ? "IO" : "CPU");
         end
      end
      cpu_req = 1'b0; io_req = 1'b0;
   endtask

   initial begin
      int lat;
      logic [DATA_W-1:0] rd;
      logic er, oth;
      int tp0, we0, ack0, got, gap;
      logic [3:0] who;

      reset_n = 1'b0;
      cpu_req = 1'b0; io_req = 1'b0; cpu_we = 1'b0; io_we = 1'b0;
      cpu_addr = '0; io_addr = '0; cpu_wdata = '0; io_wdata = '0;
      #1;
      chk("rst_mem_tp",   32'(mem_tp),   32'd0);
      chk("rst_mem_we",   32'(mem_we),   32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_din",  32'(mem_din),  32'd0);
      chk("rst_rdata",    32'(rdata),    32'd0);
      chk("rst_acks",     32'({cpu_ack, io_ack, cpu_err, io_err}), 32'd0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      // Legal CPU write
      tp0 = tp_cnt; we0 = we_cnt;
      access(1'b0, 1'b1, 12'h010, 15'h1234, 1'b0, lat, rd, er, oth);
      chk("wr_latency",   32'(lat), 32'd3);
      chk("wr_err",       32'(er),  32'd0);
      chk("wr_io_ack",    32'(oth), 32'd0);
      @(posedge clk); #1;
      chk("wr_ack_clear", 32'(cpu_ack), 32'd0);
      chk("wr_tp_pulses", 32'(tp_cnt - tp0), 32'd1);
      chk("wr_we_cycles", 32'(we_cnt - we0), 32'd3);
      chk("wr_mem_word",  32'(mem[12'h010]), 32'h1234);

      // Read back the same word
      tp0 = tp_cnt; we0 = we_cnt;
      access(1'b0, 1'b0, 12'h010, 15'h0000, 1'b0, lat, rd, er, oth);
      chk("rd_latency",   32'(lat), 32'd3);
      chk("rd_rdata",     32'(rd),  32'h1234);
      chk("rd_err",       32'(er),  32'd0);
      chk("rd_tp_pulses", 32'(tp_cnt - tp0), 32'd0);
      chk("rd_we_cycles", 32'(we_cnt - we0), 32'd0);

      // IO write to fixed memory: rejected
      tp0 = tp_cnt; we0 = we_cnt;
      access(1'b1, 1'b1, 12'h800, 15'h7FFF, 1'b0, lat, rd, er, oth);
      chk("ill_latency",   32'(lat), 32'd3);
      chk("ill_err",       32'(er),  32'd1);
      chk("ill_cpu_ack",   32'(oth), 32'd0);
      @(posedge clk); #1;
      chk("ill_err_clear", 32'(io_err), 32'd0);
      chk("ill_tp_pulses", 32'(tp_cnt - tp0), 32'd0);
      chk("ill_we_cycles", 32'(we_cnt - we0), 32'd0);
      chk("ill_mem_word",  32'(mem[12'h800]), 32'h0111);

      // CPU read at the top of the writable range, then rdata must hold
      tp0 = tp_cnt;
      access(1'b0, 1'b0, 12'h3FF, 15'h0000, 1'b0, lat, rd, er, oth);
      chk("rd3ff_latency", 32'(lat), 32'd3);
      chk("rd3ff_rdata",   32'(rd),  32'h2A5C);
      chk("rd3ff_tp",      32'(tp_cnt - tp0), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("rdata_hold",    32'(rdata), 32'h2A5C);

      // Request dropped right after acceptance still completes
      access(1'b1, 1'b1, 12'h011, 15'h0555, 1'b1, lat, rd, er, oth);
      chk("drop_latency",  32'(lat), 32'd3);
      chk("drop_err",      32'(er),  32'd0);
      chk("drop_mem_word", 32'(mem[12'h011]), 32'h0555);

      // Both requesting and held: strict alternation starting with CPU
      both_run(4, got, who, gap);
      chk("rr_ack_count", 32'(got), 32'd4);
      chk("rr_order",     32'(who), 32'b1010);
      chk("rr_gap",       32'(gap), 32'd4);

      // Reset in the PULSE state of a legal write aborts it
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h020; cpu_wdata = 15'h5555;
      @(posedge clk); #1;
      cpu_req = 1'b0;
      @(posedge clk); #1;
      chk("abort_setup_addr", 32'(mem_addr), 32'h020);
      chk("abort_setup_we",   32'(mem_we),   32'd1);
      chk("abort_setup_tp",   32'(mem_tp),   32'd0);
      tp0 = tp_cnt; ack0 = ack_cnt;
      reset_n = 1'b0;
      #1;
      chk("abort_mem_we",   32'(mem_we),   32'd0);
      chk("abort_mem_addr", 32'(mem_addr), 32'd0);
      chk("abort_mem_din",  32'(mem_din),  32'd0);
      chk("abort_rdata",    32'(rdata),    32'd0);
      repeat (4) @(negedge clk);
      chk("abort_no_ack",   32'(ack_cnt - ack0), 32'd0);
      chk("abort_no_tp",    32'(tp_cnt - tp0),   32'd0);
      chk("abort_mem_word", 32'(mem[12'h020]),   32'h0ABC);
      reset_n = 1'b1;
      $display("reset abort of write to 0x020 done");

      // The aborted access granted CPU; reset must restore CPU preference
      both_run(1, got, who, gap);
      chk("rst_pref_count", 32'(got),    32'd1);
      chk("rst_pref_cpu",   32'(who[0]), 32'd0);
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
